// File: rtl/c2_arb_pkg.sv
// Shared constants and helpers for the C2 round-robin arbiter.
// ARB_FIXED_PRIO_EN selects fixed lowest-index priority instead of round-robin.
package c2_arb_pkg;

  localparam int NUM_REQ = 4;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_BUSY = 1'b1;

  // Returns {A1,B1,A0,B0} so that the C2 cell selects input g.
  function automatic logic [3:0] idx_to_sel(
    input logic [1:0] g
  );
    return {g[1], 1'b0, g[0], g[0]};
  endfunction

endpackage

// File: rtl/c2_rr_arbiter_c2.sv
// C2 4:1 select cell: S1 = A1|B1, S0 = A0&B0.
// Output is d<S1,S0>.
module c2_rr_arbiter_c2 #(
  parameter int SIZE = 5
) (
  input  logic [SIZE-1:0] d0,
  input  logic [SIZE-1:0] d1,
  input  logic [SIZE-1:0] d2,
  input  logic [SIZE-1:0] d3,
  input  logic            a1,
  input  logic            b1,
  input  logic            a0,
  input  logic            b0,
  output logic [SIZE-1:0] y
);

  logic s1;
  logic s0;

  assign s1 = a1 | b1;
  assign s0 = a0 & b0;

  always_comb begin
    unique case ({s1, s0})
      2'b00:   y = d0;
      2'b01:   y = d1;
      2'b10:   y = d2;
      default: y = d3;
    endcase
  end

endmodule

// File: rtl/c2_rr_arbiter_rr_pick.sv
// Rotate-priority encoder: first set req bit
// scanning ptr, ptr+1, ... modulo 4.
module c2_rr_arbiter_rr_pick
  import c2_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [1:0]         ptr,
  output logic [1:0]         g,
  output logic               any
);

  assign any = |req;

  // Walk from the farthest slot back to ptr
  // so the nearest set bit wins.
  always_comb begin
    logic [1:0] idx;
    g   = '0;
    idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = ptr + 2'(k);
      if (req[idx]) g = idx;
    end
  end

endmodule

// File: rtl/c2_rr_arbiter.sv
// Round-robin arbiter sharing one C2 4:1 cell, with a registered output stage.
// Define ARB_FIXED_PRIO_EN for fixed lowest-index priority.
module c2_rr_arbiter
  import c2_arb_pkg::*;
#(
  parameter int SIZE = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [3:0]      req,
  input  logic [SIZE-1:0] d0,
  input  logic [SIZE-1:0] d1,
  input  logic [SIZE-1:0] d2,
  input  logic [SIZE-1:0] d3,
  output logic [3:0]      ack,
  output logic [SIZE-1:0] out_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [1:0]      grant
);

  logic            state_q, state_d;
  logic [1:0]      ptr_q, ptr_d;
  logic [1:0]      grant_q, grant_d;
  logic [SIZE-1:0] data_q, data_d;

  logic [1:0]      g;
  logic            any;
  logic [3:0]      sel;
  logic [SIZE-1:0] c2_y;
  logic            accept;
  logic            fire;

  c2_rr_arbiter_rr_pick u_pick (
    .req (req),
    .ptr (ptr_q),
    .g   (g),
    .any (any)
  );

  assign sel = idx_to_sel(g);

  c2_rr_arbiter_c2 #(
    .SIZE (SIZE)
  ) u_c2 (
    .d0 (d0),
    .d1 (d1),
    .d2 (d2),
    .d3 (d3),
    .a1 (sel[3]),
    .b1 (sel[2]),
    .a0 (sel[1]),
    .b0 (sel[0]),
    .y  (c2_y)
  );

  assign accept = (state_q == ST_IDLE) | out_ready;
  assign fire   = accept & any;

  // Gated by rst_n so no requester sees a capture while held in reset.
  assign ack = (fire & rst_n) ? (4'b0001 << g) : 4'b0000;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    data_d  = data_q;
    if (fire) begin
      state_d = ST_BUSY;
      grant_d = g;
      data_d  = c2_y;
`ifdef ARB_FIXED_PRIO_EN
      ptr_d   = 2'd0;
`else
      ptr_d   = g + 2'd1;
`endif
    end else if ((state_q == ST_BUSY) && out_ready) begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = (state_q == ST_BUSY);
  assign out_data  = data_q;
  assign grant     = grant_q;

endmodule

// File: tb/tb_c2_rr_arbiter.sv
// Directed self-checking bench for c2_rr_arbiter.
// Also built with ARB_FIXED_PRIO_EN to cover fixed priority.
module tb_c2_rr_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [4:0] d0, d1, d2, d3;
  logic [3:0] ack;
  logic [4:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] grant;

  int checks;
  int failures;

  c2_rr_arbiter #(.SIZE(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .d0        (d0),
    .d1        (d1),
    .d2        (d2),
    .d3        (d3),
    .ack       (ack),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .grant     (grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n     = 1'b0;
    req       = 4'hF;
    out_ready = 1'b0;
    d0 = 5'h00; d1 = 5'h00; d2 = 5'h00; d3 = 5'h00;
    #3;
    checks++;
    if (ack !== 4'b0000) begin
      failures++;
      $display("FAIL reset_ack got=%b exp=0000", ack);
    end
    checks++;
    if (out_valid !== 1'b0 || out_data !== 5'h00 || grant !== 2'd0) begin
      failures++;
      $display("FAIL reset_out got v=%b d=%h g=%0d exp v=0 d=00 g=0",
               out_valid, out_data, grant);
    end
    req = 4'h0;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_single;
    d2        = 5'h15;
    req       = 4'b0100;
    out_ready = 1'b1;
    #1;
    checks++;
    if (ack !== 4'b0100) begin
      failures++;
      $display("FAIL single_ack got=%b exp=0100", ack);
    end
    tick();
    req = 4'b0000;
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 5'h15 || grant !== 2'd2) begin
      failures++;
      $display("FAIL single_out got v=%b d=%h g=%0d exp v=1 d=15 g=2",
               out_valid, out_data, grant);
    end
    checks++;
    if (ack !== 4'b0000) begin
      failures++;
      $display("FAIL single_noack got=%b exp=0000", ack);
    end
  endtask

  task automatic test_wrap;
    d3  = 5'h0A;
    d0  = 5'h11;
    req = 4'b1000;
    #1;
    checks++;
    if (ack !== 4'b1000) begin
      failures++;
      $display("FAIL wrap_ack3 got=%b exp=1000", ack);
    end
    tick();
    req = 4'b1001;
    #1;
    checks++;
    if (grant !== 2'd3 || out_data !== 5'h0A) begin
      failures++;
      $display("FAIL wrap_g3 got g=%0d d=%h exp g=3 d=0a", grant, out_data);
    end
    checks++;
    if (ack !== 4'b0001) begin
      failures++;
      $display("FAIL wrap_ack0 got=%b exp=0001", ack);
    end
    tick();
    req = 4'b1000;
    #1;
    checks++;
    if (grant !== 2'd0 || out_data !== 5'h11 || ack !== 4'b1000) begin
      failures++;
      $display("FAIL wrap_g0 got g=%0d d=%h ack=%b exp g=0 d=11 ack=1000",
               grant, out_data, ack);
    end
    tick();
    req = 4'b0000;
    #1;
    checks++;
    if (grant !== 2'd3 || out_data !== 5'h0A) begin
      failures++;
      $display("FAIL wrap_g3b got g=%0d d=%h exp g=3 d=0a", grant, out_data);
    end
  endtask

  task automatic test_round_robin;
    logic [1:0] eg;
    d0 = 5'd1; d1 = 5'd2; d2 = 5'd3; d3 = 5'd4;
    req       = 4'hF;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      eg = 2'(i % 4);
      #1;
      checks++;
      if (ack !== (4'b0001 << eg)) begin
        failures++;
        $display("FAIL rr_ack[%0d] got=%b exp=%b", i, ack, 4'b0001 << eg);
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || grant !== eg || out_data !== 5'(eg + 1)) begin
        failures++;
        $display("FAIL rr_out[%0d] got v=%b g=%0d d=%0d exp v=1 g=%0d d=%0d",
                 i, out_valid, grant, out_data, eg, eg + 1);
      end
    end
  endtask

  task automatic test_backpressure;
    out_ready = 1'b0;
    req       = 4'b0011;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (ack !== 4'b0000 || out_valid !== 1'b1 ||
          grant !== 2'd0 || out_data !== 5'd1) begin
        failures++;
        $display("FAIL bp_hold[%0d] got ack=%b v=%b g=%0d d=%0d exp 0000 1 0 1",
                 i, ack, out_valid, grant, out_data);
      end
      tick();
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (ack !== 4'b0010) begin
      failures++;
      $display("FAIL bp_ack1 got=%b exp=0010", ack);
    end
    tick();
    checks++;
    if (grant !== 2'd1 || out_data !== 5'd2) begin
      failures++;
      $display("FAIL bp_g1 got g=%0d d=%0d exp g=1 d=2", grant, out_data);
    end
    checks++;
    if (ack !== 4'b0001) begin
      failures++;
      $display("FAIL bp_ack0 got=%b exp=0001", ack);
    end
    tick();
    checks++;
    if (grant !== 2'd0 || out_data !== 5'd1) begin
      failures++;
      $display("FAIL bp_g0 got g=%0d d=%0d exp g=0 d=1", grant, out_data);
    end
  endtask

  task automatic test_pair(output logic [4:0] last_d);
    logic [1:0] eg;
    req       = 4'b1010;
    out_ready = 1'b1;
    last_d    = 5'd0;
    for (int i = 0; i < 4; i++) begin
`ifdef ARB_FIXED_PRIO_EN
      eg = 2'd1;
`else
      eg = (i % 2 == 0) ? 2'd1 : 2'd3;
`endif
      #1;
      checks++;
      if (ack !== (4'b0001 << eg)) begin
        failures++;
        $display("FAIL pair_ack[%0d] got=%b exp=%b", i, ack, 4'b0001 << eg);
      end
      tick();
      checks++;
      if (grant !== eg || out_data !== 5'(eg + 1)) begin
        failures++;
        $display("FAIL pair_out[%0d] got g=%0d d=%0d exp g=%0d d=%0d",
                 i, grant, out_data, eg, eg + 1);
      end
      last_d = 5'(eg + 1);
    end
  endtask

  task automatic test_drain(input logic [4:0] last_d);
    req       = 4'b0000;
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b0 || out_data !== last_d) begin
      failures++;
      $display("FAIL drain got v=%b d=%0d exp v=0 d=%0d",
               out_valid, out_data, last_d);
    end
    out_ready = 1'b0;
    req       = 4'b0001;
    #1;
    checks++;
    if (ack !== 4'b0001) begin
      failures++;
      $display("FAIL idle_accept got=%b exp=0001", ack);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 5'd1) begin
      failures++;
      $display("FAIL idle_load got v=%b d=%0d exp v=1 d=1", out_valid, out_data);
    end
  endtask

  task automatic test_reset_mid;
    req       = 4'hF;
    out_ready = 1'b1;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 5'd0 ||
        grant !== 2'd0 || ack !== 4'b0000) begin
      failures++;
      $display("FAIL mid_reset got v=%b d=%0d g=%0d ack=%b exp 0 0 0 0000",
               out_valid, out_data, grant, ack);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (ack !== 4'b0001) begin
      failures++;
      $display("FAIL post_reset_ack got=%b exp=0001", ack);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || grant !== 2'd0 || out_data !== 5'd1) begin
      failures++;
      $display("FAIL post_reset_out got v=%b g=%0d d=%0d exp 1 0 1",
               out_valid, grant, out_data);
    end
  endtask

  initial begin
    logic [4:0] last_d;
    checks   = 0;
    failures = 0;
    test_reset();
    test_single();
    test_wrap();
    test_round_robin();
    test_backpressure();
    test_pair(last_d);
    test_drain(last_d);
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
